// File: rtl/bk_pipe_adder.sv
// Two-stage pipelined Brent-Kung adder with ADD/SUB/accumulate/load modes
// and optional signed saturation; the accumulator lives alongside stage 2.
module bk_pipe_adder #(
  parameter int WIDTH = 16,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  localparam int LOG    = $clog2(WIDTH);
  localparam int NSTAGE = 2 * LOG - 1;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  mode_t            s1_mode;
  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic             op_c;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] gs [0:NSTAGE];
  logic [WIDTH-1:0] ps [0:NSTAGE];
  logic [WIDTH-1:0] raw_sum;
  logic             raw_cout;
  logic             raw_ovf;
  logic [WIDTH-1:0] result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_a    <= a;
      s1_b    <= b;
      s1_cin  <= cin;
      s1_mode <= mode_t'(mode);
    end
  end

  // LOAD adds zero with no carry, so cout and ovf fall out as 0 naturally.
  always_comb begin
    op_x = s1_a;
    op_y = s1_b;
    op_c = s1_cin;
    case (s1_mode)
      MODE_ADD: begin
        op_x = s1_a;
        op_y = s1_b;
        op_c = s1_cin;
      end
      MODE_SUB: begin
        op_x = s1_a;
        op_y = ~s1_b;
        op_c = 1'b1;
      end
      MODE_ACC: begin
        op_x = acc;
        op_y = s1_a;
        op_c = s1_cin;
      end
      default: begin
        op_x = s1_a;
        op_y = '0;
        op_c = 1'b0;
      end
    endcase
  end

  assign gen  = op_x & op_y;
  assign prop = op_x ^ op_y;

  // Carry-in folded into bit 0's generate so every prefix carry includes it.
  assign gs[0] = {gen[WIDTH-1:1], gen[0] | (prop[0] & op_c)};
  assign ps[0] = prop;

  for (genvar l = 0; l < LOG; l++) begin : g_up
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i + 1) % (2 ** (l + 1))) == 0) begin : g_op
        assign gs[l+1][i] = gs[l][i] | (ps[l][i] & gs[l][i-(2**l)]);
        assign ps[l+1][i] = ps[l][i] & ps[l][i-(2**l)];
      end else begin : g_pass
        assign gs[l+1][i] = gs[l][i];
        assign ps[l+1][i] = ps[l][i];
      end
    end
  end

  for (genvar k = 1; k < LOG; k++) begin : g_down
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int L = LOG - 1 - k;
      if ((((i + 1) % (2 ** (L + 1))) == (2 ** L)) && (i >= (2 ** (L + 1)))) begin : g_op
        assign gs[LOG+k][i] = gs[LOG+k-1][i] | (ps[LOG+k-1][i] & gs[LOG+k-1][i-(2**L)]);
        assign ps[LOG+k][i] = ps[LOG+k-1][i] & ps[LOG+k-1][i-(2**L)];
      end else begin : g_pass
        assign gs[LOG+k][i] = gs[LOG+k-1][i];
        assign ps[LOG+k][i] = ps[LOG+k-1][i];
      end
    end
  end

  assign raw_sum  = prop ^ {gs[NSTAGE][WIDTH-2:0], op_c};
  assign raw_cout = gs[NSTAGE][WIDTH-1];
  assign raw_ovf  = (op_x[WIDTH-1] == op_y[WIDTH-1]) && (raw_sum[WIDTH-1] != op_x[WIDTH-1]);

  always_comb begin
    result = raw_sum;
    if (SAT && raw_ovf) begin
      result = op_x[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end

  // acc shares the stage-2 edge so a following ACC sees it without a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= result;
        cout <= raw_cout;
        ovf  <= raw_ovf;
        if (s1_mode == MODE_ACC || s1_mode == MODE_LOAD) begin
          acc <= result;
        end
      end
    end
  end

endmodule

// File: tb/tb_bk_pipe_adder.sv
// Scoreboard bench for bk_pipe_adder: five instances (various WIDTH/SAT) share
// one stimulus stream and are compared against a behavioural reference model.
module tb_bk_pipe_adder;

  localparam int ND = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        cin;
  logic [1:0]  mode;
  logic [63:0] a;
  logic [63:0] b;

  logic        o_vld  [ND];
  logic        o_cout [ND];
  logic        o_ovf  [ND];
  logic [63:0] o_sum  [ND];

  logic [15:0] s0;
  logic [15:0] s1;
  logic [7:0]  s2;
  logic [31:0] s3;
  logic [63:0] s4;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    int          due;
    bit          known;
    logic [15:0] ks0;
    logic [15:0] ks1;
    logic        kc;
    logic        ko;
  } req_t;

  req_t        q[$];
  logic [63:0] macc  [ND];
  logic [63:0] lsum  [ND];
  logic        lcout [ND];
  logic        lovf  [ND];
  int          cycle;
  int          errors;
  int          checks;

  always #5 clk = ~clk;

  bk_pipe_adder #(.WIDTH(16), .SAT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .mode(mode), .out_valid(o_vld[0]), .sum(s0), .cout(o_cout[0]), .ovf(o_ovf[0]));
  bk_pipe_adder #(.WIDTH(16), .SAT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .mode(mode), .out_valid(o_vld[1]), .sum(s1), .cout(o_cout[1]), .ovf(o_ovf[1]));
  bk_pipe_adder #(.WIDTH(8), .SAT(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[7:0]), .b(b[7:0]),
    .cin(cin), .mode(mode), .out_valid(o_vld[2]), .sum(s2), .cout(o_cout[2]), .ovf(o_ovf[2]));
  bk_pipe_adder #(.WIDTH(32), .SAT(1'b0)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[31:0]), .b(b[31:0]),
    .cin(cin), .mode(mode), .out_valid(o_vld[3]), .sum(s3), .cout(o_cout[3]), .ovf(o_ovf[3]));
  bk_pipe_adder #(.WIDTH(64), .SAT(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .cin(cin), .mode(mode), .out_valid(o_vld[4]), .sum(s4), .cout(o_cout[4]), .ovf(o_ovf[4]));

  assign o_sum[0] = {48'b0, s0};
  assign o_sum[1] = {48'b0, s1};
  assign o_sum[2] = {56'b0, s2};
  assign o_sum[3] = {32'b0, s3};
  assign o_sum[4] = s4;

  function automatic int dutWidth(input int i);
    case (i)
      0, 1:    return 16;
      2:       return 8;
      3:       return 32;
      default: return 64;
    endcase
  endfunction

  function automatic bit dutSat(input int i);
    return (i == 1) || (i == 2) || (i == 4);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Plain arithmetic reference: wide add, then mask, carry pick and clamp.
  task automatic model(input int w, input bit sat, input logic [63:0] accv, input req_t r,
                       output logic [63:0] s, output logic c, output logic o);
    logic [63:0] mask, x, y, raw, mx, mn;
    logic [64:0] full;
    logic        c0;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    case (r.mode)
      2'b00:   begin x = r.a & mask; y = r.b & mask;  c0 = r.cin; end
      2'b01:   begin x = r.a & mask; y = ~r.b & mask; c0 = 1'b1;  end
      2'b10:   begin x = accv;       y = r.a & mask;  c0 = r.cin; end
      default: begin x = r.a & mask; y = 64'd0;       c0 = 1'b0;  end
    endcase
    full = {1'b0, x} + {1'b0, y} + {64'd0, c0};
    raw  = full[63:0] & mask;
    c    = full[w];
    o    = (x[w-1] == y[w-1]) && (raw[w-1] != x[w-1]);
    if (r.mode == 2'b11) begin
      c = 1'b0;
      o = 1'b0;
    end
    mx = mask >> 1;
    mn = mask ^ mx;
    s  = (sat && o) ? (x[w-1] ? mn : mx) : raw;
  endtask

  task automatic checkCycle();
    req_t        r;
    logic [63:0] s;
    logic        c, o;
    if (q.size() > 0 && q[0].due == cycle) begin
      r = q.pop_front();
      for (int i = 0; i < ND; i++) begin
        model(dutWidth(i), dutSat(i), macc[i], r, s, c, o);
        if (r.mode[1]) macc[i] = s;
        lsum[i]  = s;
        lcout[i] = c;
        lovf[i]  = o;
        checkOutput($sformatf("d%0d.valid", i), 64'(o_vld[i]), 64'd1);
        checkOutput($sformatf("d%0d.sum", i), o_sum[i], s);
        checkOutput($sformatf("d%0d.cout", i), 64'(o_cout[i]), 64'(c));
        checkOutput($sformatf("d%0d.ovf", i), 64'(o_ovf[i]), 64'(o));
      end
      if (r.known) begin
        checkOutput("k16.sum", o_sum[0], {48'd0, r.ks0});
        checkOutput("k16sat.sum", o_sum[1], {48'd0, r.ks1});
        checkOutput("k16.cout", 64'(o_cout[0]), 64'(r.kc));
        checkOutput("k16.ovf", 64'(o_ovf[0]), 64'(r.ko));
        checkOutput("k16sat.ovf", 64'(o_ovf[1]), 64'(r.ko));
      end
    end else begin
      for (int i = 0; i < ND; i++) begin
        checkOutput($sformatf("d%0d.idle_valid", i), 64'(o_vld[i]), 64'd0);
        checkOutput($sformatf("d%0d.hold_sum", i), o_sum[i], lsum[i]);
        checkOutput($sformatf("d%0d.hold_cout", i), 64'(o_cout[i]), 64'(lcout[i]));
        checkOutput($sformatf("d%0d.hold_ovf", i), 64'(o_ovf[i]), 64'(lovf[i]));
      end
    end
  endtask

  task automatic resetModel();
    q.delete();
    for (int i = 0; i < ND; i++) begin
      macc[i]  = 64'd0;
      lsum[i]  = 64'd0;
      lcout[i] = 1'b0;
      lovf[i]  = 1'b0;
    end
  endtask

  // One cycle: check what the last edge produced, then drive the next request.
  task automatic applyStimulus(input logic rstv, input logic v, input logic [1:0] m,
                               input logic [63:0] av, input logic [63:0] bv, input logic c,
                               input bit known = 1'b0, input logic [15:0] ks0 = 16'd0,
                               input logic [15:0] ks1 = 16'd0, input logic kc = 1'b0,
                               input logic ko = 1'b0);
    req_t r;
    @(negedge clk);
    cycle++;
    checkCycle();
    rst_n    = rstv;
    in_valid = v;
    mode     = m;
    a        = av;
    b        = bv;
    cin      = c;
    if (!rstv) begin
      resetModel();
    end else if (v) begin
      r.mode  = m;
      r.a     = av;
      r.b     = bv;
      r.cin   = c;
      r.due   = cycle + 2;
      r.known = known;
      r.ks0   = ks0;
      r.ks1   = ks1;
      r.kc    = kc;
      r.ko    = ko;
      q.push_back(r);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    cycle    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    mode     = 2'b00;
    a        = 64'd0;
    b        = 64'd0;
    cin      = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);

    idle();
    $display("[TB] directed arithmetic");
    applyStimulus(1, 1, 2'b00, 64'hFFFF, 64'h0001, 0, 1, 16'h0000, 16'h0000, 1, 0);
    applyStimulus(1, 1, 2'b01, 64'h0005, 64'h0007, 0, 1, 16'hFFFE, 16'hFFFE, 0, 0);
    applyStimulus(1, 1, 2'b01, 64'h8000, 64'h0001, 0, 1, 16'h7FFF, 16'h8000, 1, 1);
    applyStimulus(1, 1, 2'b00, 64'h7FFF, 64'h0001, 0, 1, 16'h8000, 16'h7FFF, 0, 1);
    idle();

    $display("[TB] accumulate sequence");
    applyStimulus(1, 1, 2'b11, 64'h0010, 64'hFFFF, 1, 1, 16'h0010, 16'h0010, 0, 0);
    applyStimulus(1, 1, 2'b10, 64'h0001, 64'hFFFF, 0, 1, 16'h0011, 16'h0011, 0, 0);
    applyStimulus(1, 1, 2'b10, 64'h0002, 64'h0000, 0, 1, 16'h0013, 16'h0013, 0, 0);
    applyStimulus(1, 1, 2'b10, 64'h0003, 64'h0000, 0, 1, 16'h0016, 16'h0016, 0, 0);
    applyStimulus(1, 1, 2'b00, 64'h1234, 64'h0001, 0, 1, 16'h1235, 16'h1235, 0, 0);
    applyStimulus(1, 1, 2'b10, 64'h0004, 64'h0000, 0, 1, 16'h001A, 16'h001A, 0, 0);
    idle();
    idle();

    $display("[TB] reset with requests in flight");
    applyStimulus(1, 1, 2'b00, 64'h0001, 64'h0001, 0);
    applyStimulus(1, 1, 2'b00, 64'h0002, 64'h0002, 0);
    applyStimulus(0, 1, 2'b10, 64'h0055, 64'h0000, 0);
    idle();
    idle();
    applyStimulus(1, 1, 2'b10, 64'h0001, 64'h0000, 0, 1, 16'h0001, 16'h0001, 0, 0);
    idle();
    idle();

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      logic        rv, vv, cv;
      logic [1:0]  mv;
      logic [63:0] av, bv;
      rv = ($urandom_range(99) != 0);
      vv = ($urandom_range(3) != 0);
      mv = 2'($urandom_range(3));
      cv = 1'($urandom_range(1));
      av = {$urandom, $urandom};
      bv = {$urandom, $urandom};
      if ($urandom_range(7) == 0) av = {1'b0, {63{1'b1}}};
      if ($urandom_range(7) == 0) bv = {64{1'b1}};
      applyStimulus(rv, vv, mv, av, bv, cv);
    end

    repeat (4) idle();
    checkOutput("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bk_pipe_adder.md
BK_PIPE_ADDER -- requirements
Module: bk_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width; legal values 8, 16, 32, 64 (power of two).
REQ-002 SHALL have parameter SAT, default 0; 1 = saturate on signed overflow, 0 = wrap.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request this cycle.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B; ignored in ACC and LOAD modes.
REQ-008 SHALL have port cin  input  1  carry-in; ignored in SUB and LOAD modes.
REQ-009 SHALL have port mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 LOAD.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port sum  output  WIDTH  result.
REQ-012 SHALL have port cout  output  1  carry-out (SUB: 1 = no borrow).
REQ-013 SHALL have port ovf  output  1  signed overflow of the reported operation.

Function
REQ-014 SHALL use a two-stage pipeline: stage 1 registers in_valid, a, b, cin, mode; stage 2 registers out_valid, sum, cout, ovf.
REQ-015 SHALL produce the result for an input accepted at edge N on the outputs after edge N+1 (latency 2), one result per cycle, no backpressure, no gaps required between requests.
REQ-016 SHALL compute the add between stage registers with a Brent-Kung parallel-prefix carry network: bitwise generate/propagate, up-sweep of log2(WIDTH) levels, down-sweep of log2(WIDTH)-1 levels; carry chain or behavioural "+" is not permitted.
REQ-017 SHALL insert cin as carry into bit 0 so that every bit's carry, including cout, reflects cin.
REQ-018 ADD SHALL compute a + b + cin.
REQ-019 SUB SHALL compute a + ~b + 1.
REQ-020 ACC SHALL compute acc + a + cin, where acc is an internal WIDTH-bit accumulator, and write the (possibly saturated) sum into acc.
REQ-021 LOAD SHALL set sum = a, acc = a, cout = 0, ovf = 0.
REQ-022 acc SHALL change only on valid ACC or LOAD operations; ADD/SUB SHALL leave acc untouched.
REQ-023 acc SHALL be updated at the same edge as the stage-2 registers, so back-to-back ACC requests each see the result of the immediately preceding ACC/LOAD without stall.
REQ-024 ovf SHALL be 1 when both effective operands share an MSB and the raw sum MSB differs; effective operands are (a, b) for ADD, (a, ~b) for SUB, (acc, a) for ACC.
REQ-025 With SAT=1 and ovf=1, sum and any acc write SHALL clamp to 0111..1 when the effective operand MSB is 0, else to 1000..0; cout SHALL remain the raw carry.
REQ-026 With SAT=0, sum SHALL be the raw modulo-2^WIDTH result.
REQ-027 When stage 1 holds no valid request, the next edge SHALL drive out_valid=0 and SHALL hold sum, cout, ovf unchanged.

Reset
REQ-028 While rst_n=0 at an edge, the block SHALL clear out_valid, sum, cout, ovf, acc, and the stage-1 valid to 0.
REQ-029 Requests in flight when reset is asserted SHALL be discarded and SHALL never appear on the outputs.
REQ-030 in_valid sampled while rst_n=0 SHALL be ignored.
REQ-031 The first request accepted after release SHALL produce its output two edges later with acc starting from 0.

Verification
REQ-032 ADD, WIDTH=16: a=0xFFFF, b=0x0001, cin=0 -> 2 cycles later out_valid=1, sum=0x0000, cout=1, ovf=0.
REQ-033 SUB: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
REQ-034 ADD a=0x7FFF, b=0x0001 -> SAT=0: sum=0x8000, ovf=1; SAT=1: sum=0x7FFF, ovf=1.
REQ-035 Consecutive cycles LOAD a=0x0010, then ACC a=0x0001, 0x0002, 0x0003 (cin=0) -> consecutive outputs 0x0010, 0x0011, 0x0013, 0x0016; an interleaved ADD does not disturb the acc sequence.
REQ-036 Reset: rst_n low for one edge with two requests in flight -> out_valid=0 and all outputs 0 after that edge; no stale output follows; next ACC a=0x0001 yields 0x0001.
REQ-037 Random: WIDTH=8, 32, 64, random modes, operands, and in_valid gaps, checked against a reference model for sum, cout, ovf, and latency.
